// File: rtl/march_ag_pkg.sv
// march_ag_pkg: shared state encoding and sweep-direction constants for the March address generator
package march_ag_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10} state_t;
  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;
endpackage

// File: rtl/bounded_updown_ctr.sv
// bounded_updown_ctr: load/step/hold counter that flags when the next step lands on the end address
module bounded_updown_ctr #(
  parameter int SIZE = 16,
  parameter int W    = $clog2(SIZE)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         step,
  input  logic         down,
  output logic [W-1:0] cnt,
  output logic         nxt_end
);
  assign nxt_end = down ? (cnt == W'(1)) : (cnt == W'(SIZE - 2));
  // clear beats load beats step; otherwise hold
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (step) cnt <= down ? cnt - 1'b1 : cnt + 1'b1;
endmodule

// File: rtl/march_addr_gen.sv
// march_addr_gen: BIST March address sequencer with start/done handshake and abort; MARCH_AG_MULTIPASS_EN adds pass_idx and multi-pass sweeps
module march_addr_gen
  import march_ag_pkg::*;
#(
  parameter int ARRAY_SIZE = 16,
  parameter int ADDR_WIDTH = $clog2(ARRAY_SIZE),
  parameter int NUM_PASSES = 2,
  parameter int PASS_WIDTH = $clog2(NUM_PASSES) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  dir,
  input  logic                  en,
  input  logic                  abort,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic                  addr_valid,
  output logic                  last,
  output logic                  done,
  output logic                  busy
`ifdef MARCH_AG_MULTIPASS_EN
  ,
  output logic [PASS_WIDTH-1:0] pass_idx
`endif
);
`ifdef MARCH_AG_MULTIPASS_EN
  localparam bit MULTI = 1'b1;
`else
  localparam bit MULTI = 1'b0;
`endif
  state_t state, state_n;
  logic last_n, dir_q, dir_n, clr, load, step, nxt_end, more;
  logic [PASS_WIDTH-1:0] pass_q, pass_n;
  bounded_updown_ctr #(.SIZE(ARRAY_SIZE), .W(ADDR_WIDTH)) u_ctr (
    .clk(clk), .rst(rst), .clr(clr), .load(load),
    .load_val(dir == DIR_DOWN ? ADDR_WIDTH'(ARRAY_SIZE - 1) : '0),
    .step(step), .down(dir_q), .cnt(addr_out), .nxt_end(nxt_end)
  );
  assign more       = MULTI && (pass_q < PASS_WIDTH'(NUM_PASSES - 1));
  assign addr_valid = state == RUN;
  assign done       = state == DONE;
  assign busy       = state != IDLE;
`ifdef MARCH_AG_MULTIPASS_EN
  assign pass_idx = pass_q;
`endif
  // state and sweep-control registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state  <= IDLE;
      last   <= 1'b0;
      dir_q  <= DIR_UP;
      pass_q <= '0;
    end else begin
      state  <= state_n;
      last   <= last_n;
      dir_q  <= dir_n;
      pass_q <= pass_n;
    end
  // next state and counter control; abort wins over start and en
  always_comb begin
    state_n = state;
    last_n  = last;
    dir_n   = dir_q;
    pass_n  = pass_q;
    clr     = 1'b0;
    load    = 1'b0;
    step    = 1'b0;
    if (abort) begin
      state_n = IDLE;
      last_n  = 1'b0;
      pass_n  = '0;
      clr     = 1'b1;
    end else if (state == IDLE && start) begin
      state_n = RUN;
      load    = 1'b1;
      dir_n   = dir;
      pass_n  = '0;
    end else if (state == RUN && en && !last) begin
      step   = 1'b1;
      last_n = nxt_end;
    end else if (state == RUN && en && more) begin
      dir_n  = ~dir_q;
      pass_n = pass_q + 1'b1;
      last_n = 1'b0;
    end else if (state == RUN && en) begin
      state_n = DONE;
      last_n  = 1'b0;
    end else if (state == DONE) state_n = IDLE;
  end
endmodule
